// File: rtl/freq_scan_ctrl_pkg.sv
// Widths, defaults and state encoding shared by the frequency scan sequencer.
package freq_scan_ctrl_pkg;

  localparam int FREQ_CNT_NBIT  = 16;
  localparam int FREQ_TO_NBIT   = 24;
  localparam int FREQ_DATA_NBIT = 32;
  localparam int FREQ_NCH       = 8;
  localparam int FREQ_SETTLE    = 4;

  typedef enum logic [2:0] {
    FSC_IDLE   = 3'd0,
    FSC_SEL    = 3'd1,
    FSC_SETTLE = 3'd2,
    FSC_FIRE   = 3'd3,
    FSC_ARM    = 3'd4,
    FSC_WAIT   = 3'd5,
    FSC_WRITE  = 3'd6,
    FSC_NEXT   = 3'd7
  } fsc_state_e;

endpackage

// File: rtl/freq_ch_pick.sv
// Finds the lowest enabled channel above the current one, optionally
// wrapping around to the lowest enabled channel overall.
module freq_ch_pick
  import freq_scan_ctrl_pkg::*;
#(
  parameter int N_CH    = FREQ_NCH,
  parameter int CH_NBIT = 3
) (
  input  logic [N_CH-1:0]    mask,
  input  logic [CH_NBIT-1:0] cur,
  input  logic               wrap,
  output logic [CH_NBIT-1:0] nxt,
  output logic               found
);

  logic [CH_NBIT-1:0] above_idx;
  logic [CH_NBIT-1:0] low_idx;
  logic               above_ok;
  logic               low_ok;

  // Scan downward so the last hit recorded is the lowest qualifying bit.
  always_comb begin
    above_idx = '0;
    low_idx   = '0;
    above_ok  = 1'b0;
    low_ok    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_ok  = 1'b1;
        low_idx = CH_NBIT'(i);
        if (i > int'(cur)) begin
          above_ok  = 1'b1;
          above_idx = CH_NBIT'(i);
        end else begin
          above_ok  = above_ok;
          above_idx = above_idx;
        end
      end else begin
        low_ok  = low_ok;
        low_idx = low_idx;
      end
    end
  end

  // Prefer a channel above the current one; fall back to wrap-around.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    if (above_ok) begin
      nxt   = above_idx;
      found = 1'b1;
    end else if (wrap && low_ok) begin
      nxt   = low_idx;
      found = 1'b1;
    end else begin
      nxt   = '0;
      found = 1'b0;
    end
  end

endmodule

// File: rtl/freq_scan_ctrl.sv
// Scan sequencer: walks the enabled pins through one shared freq_m engine
// and emits one result beat per measured channel.
module freq_scan_ctrl
  import freq_scan_ctrl_pkg::*;
#(
  parameter int N_CH    = FREQ_NCH,
  parameter int CH_NBIT = 3,
  parameter int SETTLE  = FREQ_SETTLE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      i_loop,
  input  logic [N_CH-1:0]           i_mask,
  input  logic [FREQ_CNT_NBIT-1:0]  i_cnt,
  input  logic [FREQ_TO_NBIT-1:0]   i_timeout,
  input  logic [N_CH-1:0]           i_io,
  output logic                      m_start,
  output logic [FREQ_CNT_NBIT-1:0]  m_cnt,
  output logic [FREQ_TO_NBIT-1:0]   m_timeout,
  output logic                      m_io,
  input  logic [FREQ_DATA_NBIT-1:0] m_freq,
  input  logic [FREQ_CNT_NBIT-1:0]  m_rcnt,
  input  logic                      m_err,
  input  logic                      m_done,
  output logic                      o_wr,
  output logic [CH_NBIT-1:0]        o_ch,
  output logic [FREQ_DATA_NBIT-1:0] o_freq,
  output logic [FREQ_CNT_NBIT-1:0]  o_cnt,
  output logic                      o_err,
  output logic                      busy,
  output logic                      done,
  output logic                      o_aborted
);

  localparam int SET_NBIT = $clog2(SETTLE + 1);

  fsc_state_e                state_q, state_d;
  logic [CH_NBIT-1:0]        sel_q, sel_d;
  logic [N_CH-1:0]           mask_q, mask_d;
  logic [FREQ_CNT_NBIT-1:0]  cnt_q, cnt_d;
  logic [FREQ_TO_NBIT-1:0]   to_q, to_d;
  logic                      loop_q, loop_d;
  logic                      abort_pend_q, abort_pend_d;
  logic [SET_NBIT-1:0]       settle_q, settle_d;
  logic                      m_start_q, m_start_d;
  logic                      m_io_q, m_io_d;
  logic                      o_wr_q, o_wr_d;
  logic [CH_NBIT-1:0]        o_ch_q, o_ch_d;
  logic [FREQ_DATA_NBIT-1:0] o_freq_q, o_freq_d;
  logic [FREQ_CNT_NBIT-1:0]  o_cnt_q, o_cnt_d;
  logic                      o_err_q, o_err_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      o_aborted_q, o_aborted_d;

  logic [N_CH-1:0]           pick_mask;
  logic [CH_NBIT-1:0]        pick_cur;
  logic                      pick_wrap;
  logic [CH_NBIT-1:0]        pick_idx;
  logic                      pick_found;

  freq_ch_pick #(
    .N_CH    (N_CH),
    .CH_NBIT (CH_NBIT)
  ) u_pick (
    .mask  (pick_mask),
    .cur   (pick_cur),
    .wrap  (pick_wrap),
    .nxt   (pick_idx),
    .found (pick_found)
  );

  // Next-state, latch and output-register computation.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    loop_d       = loop_q;
    settle_d     = settle_q;
    m_start_d    = 1'b0;
    m_io_d       = i_io[sel_q];
    o_wr_d       = 1'b0;
    o_ch_d       = o_ch_q;
    o_freq_d     = o_freq_q;
    o_cnt_d      = o_cnt_q;
    o_err_d      = o_err_q;
    done_d       = 1'b0;
    o_aborted_d  = 1'b0;
    pick_mask    = mask_q;
    pick_cur     = sel_q;
    pick_wrap    = loop_q;
    if ((state_q != FSC_IDLE) && abort) begin
      abort_pend_d = 1'b1;
    end else begin
      abort_pend_d = abort_pend_q;
    end

    case (state_q)
      FSC_IDLE: begin
        // Nothing is above the top index, so forced wrap yields the lowest bit.
        pick_mask = i_mask;
        pick_cur  = CH_NBIT'(N_CH - 1);
        pick_wrap = 1'b1;
        if (start) begin
          mask_d       = i_mask;
          cnt_d        = i_cnt;
          to_d         = i_timeout;
          loop_d       = i_loop;
          abort_pend_d = 1'b0;
          if (pick_found) begin
            sel_d   = pick_idx;
            state_d = FSC_SEL;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = FSC_IDLE;
        end
      end
      FSC_SEL: begin
        if (abort_pend_q) begin
          state_d     = FSC_IDLE;
          done_d      = 1'b1;
          o_aborted_d = 1'b1;
        end else begin
          settle_d = SET_NBIT'(SETTLE - 1);
          state_d  = FSC_SETTLE;
        end
      end
      FSC_SETTLE: begin
        if (abort_pend_q) begin
          state_d     = FSC_IDLE;
          done_d      = 1'b1;
          o_aborted_d = 1'b1;
        end else if (settle_q == '0) begin
          state_d   = FSC_FIRE;
          m_start_d = 1'b1;
        end else begin
          settle_d = settle_q - SET_NBIT'(1);
        end
      end
      FSC_FIRE: begin
        state_d = FSC_ARM;
      end
      FSC_ARM: begin
        state_d = FSC_WAIT;
      end
      FSC_WAIT: begin
        if (m_done) begin
          if (abort_pend_q) begin
            state_d     = FSC_IDLE;
            done_d      = 1'b1;
            o_aborted_d = 1'b1;
          end else begin
            o_wr_d   = 1'b1;
            o_ch_d   = sel_q;
            o_freq_d = m_freq;
            o_cnt_d  = m_rcnt;
            o_err_d  = m_err;
            state_d  = FSC_WRITE;
          end
        end else begin
          state_d = FSC_WAIT;
        end
      end
      FSC_WRITE: begin
        state_d = FSC_NEXT;
      end
      FSC_NEXT: begin
        if (abort_pend_q) begin
          state_d     = FSC_IDLE;
          done_d      = 1'b1;
          o_aborted_d = 1'b1;
        end else if (pick_found) begin
          sel_d   = pick_idx;
          state_d = FSC_SEL;
        end else begin
          state_d = FSC_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = FSC_IDLE;
      end
    endcase

    busy_d = (state_d != FSC_IDLE);
  end

  // State, latched setup and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FSC_IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      loop_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      settle_q     <= '0;
      m_start_q    <= 1'b0;
      m_io_q       <= 1'b0;
      o_wr_q       <= 1'b0;
      o_ch_q       <= '0;
      o_freq_q     <= '0;
      o_cnt_q      <= '0;
      o_err_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      o_aborted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      loop_q       <= loop_d;
      abort_pend_q <= abort_pend_d;
      settle_q     <= settle_d;
      m_start_q    <= m_start_d;
      m_io_q       <= m_io_d;
      o_wr_q       <= o_wr_d;
      o_ch_q       <= o_ch_d;
      o_freq_q     <= o_freq_d;
      o_cnt_q      <= o_cnt_d;
      o_err_q      <= o_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      o_aborted_q  <= o_aborted_d;
    end
  end

  assign m_start   = m_start_q;
  assign m_cnt     = cnt_q;
  assign m_timeout = to_q;
  assign m_io      = m_io_q;
  assign o_wr      = o_wr_q;
  assign o_ch      = o_ch_q;
  assign o_freq    = o_freq_q;
  assign o_cnt     = o_cnt_q;
  assign o_err     = o_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign o_aborted = o_aborted_q;

endmodule

// File: doc/freq_scan_ctrl.md
# freq_scan_ctrl

Scan sequencer that shares one `freq_m` frequency-measurement engine among `N_CH` input pins. It takes a channel mask and a measurement setup from the host-command layer, then visits every enabled pin in ascending order. For each pin it drives the engine's IO mux, waits for the synchronizer to settle, runs one measurement and emits one result beat per channel. It sits between the USB command decoder and `freq_m`, and optionally repeats the scan continuously.

## Interface
Parameters:
- `N_CH`, 8: number of measurable pins (2..32).
- `CH_NBIT`, 3: width of channel index, equal to ceil(log2(N_CH)).
- `SETTLE`, 4: idle cycles after a mux change before `m_start`, at least 3, which covers the 2-flop synchronizer plus the edge register in `freq_m`.

Ports (widths from `globals.v`):
- `clk` in 1: single clock, shared with `freq_m`.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a scan; ignored while `busy`.
- `abort` in 1: one-cycle pulse; stops the scan.
- `i_loop` in 1: when 1, restart from the first enabled channel after the last one.
- `i_mask` in N_CH: channel enables; latched at `start`.
- `i_cnt` in FREQ_CNT_NBIT: number of edges to measure per channel; latched at `start`.
- `i_timeout` in FREQ_TO_NBIT: timeout per channel; latched at `start`.
- `i_io` in N_CH: raw pins.
- `m_start` out 1: start pulse to `freq_m`.
- `m_cnt` out FREQ_CNT_NBIT: edge count to `freq_m`.
- `m_timeout` out FREQ_TO_NBIT: timeout to `freq_m`.
- `m_io` out 1: selected pin, i.e. `i_io[sel]` registered once.
- `m_freq` in FREQ_DATA_NBIT: `freq_m` frequency result.
- `m_rcnt` in FREQ_CNT_NBIT: `freq_m` edge-count result.
- `m_err` in 1: `freq_m` error flag.
- `m_done` in 1: `freq_m` done level.
- `o_wr` out 1: one-cycle result strobe.
- `o_ch` out CH_NBIT: channel index of the result.
- `o_freq` out FREQ_DATA_NBIT: captured frequency.
- `o_cnt` out FREQ_CNT_NBIT: captured edge count.
- `o_err` out 1: captured timeout flag.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse on return to IDLE.
- `o_aborted` out 1: valid with `done`; 1 if the scan ended by abort.

## Operation
State machine with states IDLE, SEL, SETTLE, FIRE, ARM, WAIT, WRITE, NEXT.
- **IDLE:**
  - `start` latches mask, cnt, timeout and loop, and clears abort_pend.
  - If the mask is 0, pulse `done` next cycle and stay in IDLE.
  - Otherwise `sel` = lowest set bit, then go to SEL.
- **SEL:** update the mux, load the settle counter with SETTLE-1, go to SETTLE.
- **SETTLE:** count down to 0, then go to FIRE. If abort_pend is set here or in SEL, go to IDLE immediately.
- **FIRE:** `m_start`=1 for exactly one cycle, then go to ARM.
- **ARM:** a single guard cycle; `m_done` is ignored here because the engine clears it only after seeing start. Go to WAIT.
- **WAIT:** hold until `m_done`=1.
  - If abort_pend is set, discard the result and go to IDLE.
  - Otherwise go to WRITE.
- **WRITE:** register `m_freq`, `m_rcnt`, `m_err` and `sel` onto `o_*`, pulse `o_wr`, go to NEXT.
- **NEXT:** pick the lowest set mask bit above `sel`.
  - If one exists, go to SEL.
  - Else if loop is set, take the lowest set bit and go to SEL.
  - Else go to IDLE with a `done` pulse.
- **abort:** sets abort_pend in any non-IDLE state. An in-flight engine run is never cut short, because `freq_m` has no abort input. The abort takes effect at the next SEL, SETTLE, WAIT-complete or NEXT. `o_aborted`=1 with that `done`.
- `m_cnt` and `m_timeout` are driven from the latched copies for the whole scan.
- If the mask has a single bit set and loop is on, the same channel repeats with a SEL/SETTLE each pass.

## Timing
- Reset values: all outputs 0, `sel`=0, state IDLE, latches 0.
- With `start` at cycle 0: `busy` goes high at 1 (SEL), SETTLE spans cycles 2..SETTLE+1, `m_start` fires at SETTLE+2, ARM is at SETTLE+3.
- Once `m_done` is seen at cycle D: `o_wr` at D+1, NEXT at D+2, the next SEL at D+3 or `done` at D+3.
- `start` and `abort` in the same IDLE cycle: `start` wins and abort is ignored.
- `abort` in IDLE: no effect.
- `start` while busy: ignored.
- `m_done` already high at FIRE (left over from the previous run) is masked by ARM.
- Reset mid-scan: immediate return to IDLE, no `done` pulse.

## Structure
- Add to `globals.v`: `FREQ_NCH`, `FREQ_SETTLE`, and the state encodings `FSC_IDLE` through `FSC_NEXT` (3 bits).
- One combinational sub-module, `freq_ch_pick`, with inputs mask, current index and a wrap enable, and outputs next index and found.
- `freq_m` is instantiated at the top level next to this block, not inside it.

## Test plan
- Mask 8'b0010_0101, cnt 4, 1 MHz on pins 0/2/5 (clk 100 MHz) -> three `o_wr` beats with ch 0,2,5, `o_err` 0, each `o_freq` ≈ 4×100, `done` once, `o_aborted` 0.
- Mask 0 -> `done` at cycle 1, no `m_start`, `busy` never high.
- Pin 2 static, timeout small -> ch 2 beat with `o_err`=1, scan continues to ch 5.
- Loop on, mask 8'b1000_0001 -> sequence 0,7,0,7…. `abort` during ch 7 WAIT -> ch 7 result discarded, `done` with `o_aborted`=1.
- `m_start` spacing: check SETTLE=4 gives exactly 4 SETTLE cycles after each SEL. A second `start` while busy is ignored.
- Deassert `rst_n` asynchronously in WAIT -> all outputs 0 the same cycle, then a fresh scan works.
